// File: rtl/i2c_target_if.sv
// i2c_target_if: application-side payload and status signals of the I2C target
interface i2c_target_if;
  logic [15:0] tx_data;
  logic        tx_two_bytes;
  logic [15:0] rx_data;
  logic [1:0]  rx_count;
  logic        write_done;
  logic        read_req;
  logic        busy;
  modport slave (input tx_data, tx_two_bytes, output rx_data, rx_count, write_done, read_req, busy);
  modport master (output tx_data, tx_two_bytes, input rx_data, rx_count, write_done, read_req, busy);
endinterface

// File: rtl/i2c_target.sv
// i2c_target: oversampled I2C target, fixed 7-bit address, write/read of up to two bytes
module i2c_target #(
  parameter logic [6:0] ADDR = 7'h2A
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  inout  wire  sda,
  i2c_target_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_WAIT} state_t;
  state_t state, state_d;
  logic [2:0] scl_r, sda_r;
  logic [3:0] cnt, cnt_d;
  logic [7:0] sh, sh_d, tx_sh, tx_sh_d, tx_lo, tx_lo_d, first;
  logic rw, rw_d, oe, oe_d, more, more_d, busy, busy_d, wr, wr_d;
  logic [15:0] rx_data, rx_data_d;
  logic [1:0] rx_count, rx_count_d;
  logic write_done, write_done_d, read_req, read_req_d;
  logic sda_s, rise, fall, start, stop;
  assign sda_s = sda_r[1];
  assign rise = scl_r[1] & ~scl_r[2];
  assign fall = ~scl_r[1] & scl_r[2];
  assign start = scl_r[1] & scl_r[2] & sda_r[2] & ~sda_r[1];
  assign stop = scl_r[1] & scl_r[2] & ~sda_r[2] & sda_r[1];
  assign first = bus.tx_two_bytes ? bus.tx_data[15:8] : bus.tx_data[7:0];
  assign sda = oe ? 1'b0 : 1'bz;
  assign bus.rx_data = rx_data;
  assign bus.rx_count = rx_count;
  assign bus.write_done = write_done;
  assign bus.read_req = read_req;
  assign bus.busy = busy;
  // two-flop synchronizers plus one history stage; reset high so no false edges
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      scl_r <= '1;
      sda_r <= '1;
    end else begin
      scl_r <= {scl_r[1:0], scl};
      sda_r <= {sda_r[1:0], sda};
    end
  // state and datapath registers; async clear releases sda at once
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      cnt <= '0;
      sh <= '0;
      tx_sh <= '0;
      tx_lo <= '0;
      rw <= 1'b0;
      oe <= 1'b0;
      more <= 1'b0;
      busy <= 1'b0;
      wr <= 1'b0;
      rx_data <= '0;
      rx_count <= '0;
      write_done <= 1'b0;
      read_req <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      sh <= sh_d;
      tx_sh <= tx_sh_d;
      tx_lo <= tx_lo_d;
      rw <= rw_d;
      oe <= oe_d;
      more <= more_d;
      busy <= busy_d;
      wr <= wr_d;
      rx_data <= rx_data_d;
      rx_count <= rx_count_d;
      write_done <= write_done_d;
      read_req <= read_req_d;
    end
  // next state: START/STOP override bit handling; bits sampled on rise, sda changed on fall
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    sh_d = sh;
    tx_sh_d = tx_sh;
    tx_lo_d = tx_lo;
    rw_d = rw;
    oe_d = oe;
    more_d = more;
    busy_d = busy;
    wr_d = wr;
    rx_data_d = rx_data;
    rx_count_d = rx_count;
    write_done_d = 1'b0;
    read_req_d = 1'b0;
    if (start || stop) begin
      state_d = start ? S_ADDR : S_IDLE;
      cnt_d = '0;
      oe_d = 1'b0;
      busy_d = 1'b0;
      wr_d = 1'b0;
      write_done_d = wr && rx_count != 2'd0;
      rx_count_d = start ? 2'd0 : rx_count;
    end else begin
      case (state)
        S_ADDR: begin
          if (rise) begin
            sh_d = {sh[6:0], sda_s};
            cnt_d = cnt + 4'd1;
            state_d = (cnt == 4'd7 && sh[6:0] != ADDR) ? S_WAIT : S_ADDR;
          end
          if (fall && cnt == 4'd8) begin
            state_d = S_ADDR_ACK;
            oe_d = 1'b1;
            busy_d = 1'b1;
            rw_d = sh[0];
          end
        end
        S_ADDR_ACK: if (fall) begin
          state_d = rw ? S_RD_BYTE : S_WR_BYTE;
          cnt_d = rw ? 4'd1 : 4'd0;
          oe_d = rw & ~first[7];
          wr_d = ~rw;
          read_req_d = rw;
          tx_sh_d = rw ? {first[6:0], 1'b0} : tx_sh;
          tx_lo_d = rw ? bus.tx_data[7:0] : tx_lo;
          more_d = rw ? bus.tx_two_bytes : more;
        end
        S_WR_BYTE: begin
          if (rise) begin
            sh_d = {sh[6:0], sda_s};
            cnt_d = cnt + 4'd1;
          end
          if (fall && cnt == 4'd8) begin
            state_d = S_WR_ACK;
            oe_d = 1'b1;
            rx_data_d = {rx_data[7:0], sh};
            rx_count_d = rx_count == 2'd3 ? 2'd3 : rx_count + 2'd1;
          end
        end
        S_WR_ACK: if (fall) begin
          state_d = S_WR_BYTE;
          oe_d = 1'b0;
          cnt_d = '0;
        end
        S_RD_BYTE: if (fall) begin
          state_d = cnt == 4'd8 ? S_RD_ACK : S_RD_BYTE;
          oe_d = cnt != 4'd8 && !tx_sh[7];
          tx_sh_d = {tx_sh[6:0], 1'b0};
          cnt_d = cnt + 4'd1;
        end
        S_RD_ACK: if (rise) begin
          state_d = sda_s ? S_WAIT : S_RD_BYTE;
          busy_d = !sda_s;
          tx_sh_d = more ? tx_lo : 8'hFF;
          more_d = 1'b0;
          cnt_d = '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed bus-level checks of the I2C target
module tb_i2c_target;
  localparam int Q = 80;
  logic clk = 1'b0, rst = 1'b0, scl = 1'b1, m_low = 1'b0;
  wire sda;
  int n_run = 0, n_fail = 0, wd_cnt = 0, rr_cnt = 0, busy_cnt = 0, drv_cnt = 0;
  i2c_target_if bus ();
  i2c_target dut (.clk(clk), .rst(rst), .scl(scl), .sda(sda), .bus(bus));
  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);
  always #5 clk = ~clk;
  // pulse-width and bus-activity monitors
  always @(posedge clk) begin
    wd_cnt <= wd_cnt + int'(bus.write_done);
    rr_cnt <= rr_cnt + int'(bus.read_req);
    busy_cnt <= busy_cnt + int'(bus.busy);
    drv_cnt <= drv_cnt + int'(sda === 1'b0 && !m_low);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic bit_io(input logic b, output logic r);
    m_low = !b; #Q;
    scl = 1'b1; #Q;
    r = sda; #Q;
    scl = 1'b0; #Q;
  endtask
  task automatic do_start;
    m_low = 1'b0; #Q;
    scl = 1'b1; #Q;
    m_low = 1'b1; #Q;
    scl = 1'b0; #Q;
  endtask
  task automatic do_stop;
    m_low = 1'b1; #Q;
    scl = 1'b1; #Q;
    m_low = 1'b0; #Q;
  endtask
  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(d[i], r);
    bit_io(1'b1, r);
    ack = !r;
  endtask
  task automatic rd_byte(input logic ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, r);
      d[i] = r;
    end
    bit_io(!ack, r);
  endtask
  initial begin
    logic a, r;
    logic [7:0] d, v;
    int wd0, rr0, bz0, dv0;
    bus.tx_data = 16'h0;
    bus.tx_two_bytes = 1'b0;
    @(negedge clk);
    #40;
    check("rst_sda", sda, 1);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_rx_count", bus.rx_count, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_pulses", {bus.write_done, bus.read_req}, 0);
    rst = 1'b1; #Q;
    wd0 = wd_cnt;
    do_start;
    wr_byte(8'h54, a); check("w1_addr_ack", a, 1);
    check("w1_busy", bus.busy, 1);
    wr_byte(8'hA5, a); check("w1_data_ack", a, 1);
    do_stop; #Q;
    check("w1_rx_lo", bus.rx_data[7:0], 8'hA5);
    check("w1_count", bus.rx_count, 1);
    check("w1_done", wd_cnt - wd0, 1);
    check("w1_busy_off", bus.busy, 0);
    wd0 = wd_cnt;
    do_start;
    wr_byte(8'h54, a); check("w2_addr_ack", a, 1);
    wr_byte(8'h12, a); check("w2_ack0", a, 1);
    wr_byte(8'h34, a); check("w2_ack1", a, 1);
    do_stop; #Q;
    check("w2_rx", bus.rx_data, 16'h1234);
    check("w2_count", bus.rx_count, 2);
    check("w2_done", wd_cnt - wd0, 1);
    wd0 = wd_cnt; rr0 = rr_cnt; bz0 = busy_cnt; dv0 = drv_cnt;
    do_start;
    wr_byte(8'h56, a); check("nm_addr_nack", a, 0);
    wr_byte(8'h00, a); check("nm_data_nack", a, 0);
    do_stop; #Q;
    check("nm_driven", drv_cnt - dv0, 0);
    check("nm_busy", busy_cnt - bz0, 0);
    check("nm_pulses", (wd_cnt - wd0) + (rr_cnt - rr0), 0);
    check("nm_rx_kept", bus.rx_data, 16'h1234);
    rr0 = rr_cnt;
    bus.tx_data = 16'hBEEF;
    bus.tx_two_bytes = 1'b1;
    do_start;
    wr_byte(8'h55, a); check("r2_addr_ack", a, 1);
    bus.tx_data = 16'h0000;
    bus.tx_two_bytes = 1'b0;
    rd_byte(1'b1, d); check("r2_byte0", d, 8'hBE);
    check("r2_busy", bus.busy, 1);
    rd_byte(1'b0, d); check("r2_byte1", d, 8'hEF);
    check("r2_busy_off", bus.busy, 0);
    do_stop; #Q;
    check("r2_req", rr_cnt - rr0, 1);
    rr0 = rr_cnt;
    bus.tx_data = 16'h00C3;
    do_start;
    wr_byte(8'h55, a); check("r1_addr_ack", a, 1);
    rd_byte(1'b1, d); check("r1_byte0", d, 8'hC3);
    rd_byte(1'b0, d); check("r1_pad", d, 8'hFF);
    do_stop; #Q;
    check("r1_req", rr_cnt - rr0, 1);
    check("r1_busy_off", bus.busy, 0);
    wd0 = wd_cnt;
    do_start;
    wr_byte(8'h54, a); check("rs_addr_ack", a, 1);
    v = 8'h77;
    for (int i = 7; i >= 0; i--) bit_io(v[i], r);
    m_low = 1'b0; #Q;
    scl = 1'b1; #Q;
    check("rs_ack_driven", sda, 0);
    check("rs_rx_pre", bus.rx_data, 16'h3477);
    rst = 1'b0; #1;
    check("rs_sda_free", sda, 1);
    check("rs_rx_clr", bus.rx_data, 0);
    check("rs_count_clr", bus.rx_count, 0);
    check("rs_busy_clr", bus.busy, 0);
    #(Q - 1);
    scl = 1'b0; #Q;
    rst = 1'b1; #Q;
    scl = 1'b1; #Q;
    do_start;
    wr_byte(8'h54, a); check("ra_addr_ack", a, 1);
    wr_byte(8'h9C, a); check("ra_data_ack", a, 1);
    do_start;
    check("sr_done", wd_cnt - wd0, 1);
    check("sr_count_clr", bus.rx_count, 0);
    check("sr_rx_kept", bus.rx_data, 16'h009C);
    wr_byte(8'h54, a); check("sr_addr_ack", a, 1);
    wr_byte(8'h01, a); check("sr_data_ack", a, 1);
    do_stop; #Q;
    check("sr_rx", bus.rx_data, 16'h9C01);
    check("sr_count", bus.rx_count, 1);
    check("sr_done_total", wd_cnt - wd0, 2);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (slave) endpoint: the responder end of the bus driven by the team's `i2c` master. Oversamples open-drain `scl`/`sda` on its own system clock, detects START/STOP, matches a fixed 7-bit address, and ACKs. It receives one or two write bytes (MSB first), or returns one or two read bytes from a latched `tx_data` word. No clock stretching, no 10-bit addressing, no general call.

## Interface
- `ADDR`, 7'h2A, target address compared against the first byte after START.
- `clk` input 1: system clock; must be ≥ 8× SCL frequency.
- `rst` input 1: reset, asynchronous, active-low.
- `scl` input 1: bus clock (observed only, never driven).
- `sda` inout 1: bus data; driven `1'b0` or released `1'bz` only.
- `tx_data` input 16: read payload, latched at address ACK of a read.
- `tx_two_bytes` input 1: latched with `tx_data`. 1 → send `[15:8]` then `[7:0]`; 0 → send `[7:0]` only.
- `rx_data` output 16: write payload shift register; each byte enters at `[7:0]`, previous `[7:0]` moves to `[15:8]`.
- `rx_count` output 2: write bytes received this transaction, saturates at 3.
- `write_done` output 1: one-cycle pulse at STOP/repeated START ending an addressed write with `rx_count` ≥ 1.
- `read_req` output 1: one-cycle pulse on the cycle `tx_data` is latched.
- `busy` output 1: high from address match until STOP/START/NACK-exit.

## Operation
- Input path: `scl`, `sda` (z/1 read as 1) pass through 2-flop synchronizers plus one history flop. Edge detection uses the synchronized values only.
- START: `sda_s` 1→0 while `scl_s` = 1. STOP: `sda_s` 0→1 while `scl_s` = 1. Both are recognized in every state and take priority over bit processing.
- Bits are sampled on `scl_s` rising edges. `sda` drive changes only on `scl_s` falling edges.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address + R/W).
  - ADDR_ACK.
  - WR_BYTE.
  - WR_ACK.
  - RD_BYTE.
  - RD_ACK.
  - WAIT: released, ignore bus until START/STOP.
- START from any state → ADDR, with bit counter = 0 and `rx_count` = 0. If the transaction being ended was an addressed write with `rx_count` ≥ 1, pulse `write_done`.
- STOP from any state → IDLE, with `write_done` pulsed under the same condition. `sda` released on the same cycle.
- ADDR, after the 8th rising edge:
  - Match: on the next falling edge drive `sda` low, set `busy`, go to ADDR_ACK.
  - Mismatch: go to WAIT with `sda` untouched.
- ADDR_ACK, on the falling edge ending the ACK slot:
  - W: release `sda`, go to WR_BYTE.
  - R: latch `tx_data`/`tx_two_bytes`, pulse `read_req`, drive bit 7 of the first byte, go to RD_BYTE.
- WR_BYTE: 8 rising edges shift into a byte register. Then drive ACK on the falling edge, update `rx_data`, increment `rx_count`, go to WR_ACK. The following falling edge releases `sda` and returns to WR_BYTE. Writes of unlimited length are ACKed; `rx_data` keeps the last two bytes.
- RD_BYTE: each falling edge drives the next bit, MSB first (drive low for 0, release for 1). After bit 0's falling edge release `sda` and go to RD_ACK.
- RD_ACK: sample `sda_s` at the rising edge.
  - 0 (ACK): go to RD_BYTE with the next byte: `[7:0]` after `[15:8]`; 8'hFF after the final latched byte.
  - 1 (NACK): clear `busy`, go to WAIT.
- Reset: all outputs 0, `sda` released, state IDLE, counters 0.

## Timing
- Bus edge → internal detection: 3 `clk` (2 sync + 1 edge register). Drive change is applied 1 `clk` after detection, so total `sda` delay after a real SCL fall is ≤ 4 `clk`. This must stay below the SCL low time, which holds at ≥ 8× oversampling.
- `write_done` and `read_req` are registered, exactly one `clk` wide.
- `rx_data`/`rx_count` update on the cycle the ACK is first driven and stay stable until the next byte or the next START.
- Simultaneous START detection and a bit edge cannot occur, because SCL is stable high. Reset assertion mid-byte releases `sda` within the same cycle via async clear.

## Test plan
- Write 1 byte 0xA5 to 0x2A: target ACKs the address and the data; after STOP `rx_data[7:0]` = 8'hA5, `rx_count` = 1, one `write_done` pulse.
- Write 2 bytes 0x12, 0x34: both ACKed; `rx_data` = 16'h1234, `rx_count` = 2.
- Address 0x2B: `sda` never driven by the target; master sees NACK; `busy` stays 0; no pulses.
- Read 2 bytes, `tx_data` = 16'hBEEF, `tx_two_bytes` = 1: master receives 0xBE, ACKs, receives 0xEF, NACKs; `read_req` pulses once; `busy` drops after the NACK.
- Read 1 byte with `tx_two_bytes` = 0, `tx_data` = 16'h00C3: 0xC3 returned. A master ACK followed by another byte returns 0xFF.
- Reset asserted mid write byte: `sda` released immediately, outputs 0. Next START + 0x2A/W is ACKed normally. Repeated START mid-write pulses `write_done` and restarts ADDR.
